// File: rtl/instr_sequencer_pkg.sv
// Shared constants, instruction-class codes and sequencer state encoding
// for the instruction fetch/issue controller.
package instr_sequencer_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int ADDR_BITS   = 5;
  localparam int LEN_STD     = 3;
  localparam int LEN_LOAD    = 4;
  localparam int LEN_STORE   = 3;

  // Wide enough for the longest class length plus the one-cycle lead-in.
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    CLS_HALT  = 2'b00,
    CLS_STD   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } instr_cls_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port plus the issue bus toward the control unit.
interface instr_sequencer_if
  import instr_sequencer_pkg::*;
#(
  parameter int IW = INSTR_WIDTH,
  parameter int AW = ADDR_BITS
) ();

  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          retire;

  // The sequencer drives addresses and the issue bus.
  modport master (
    output imem_addr,
    input  imem_rdata,
    output instr_out,
    output instr_valid,
    output retire
  );

  // Memory/CU side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  instr_out,
    input  instr_valid,
    input  retire
  );

endinterface

// File: rtl/instr_sequencer_issue_len_lut.sv
// Instruction class to issue-cycle-count decode; halt decodes to zero.
module issue_len_lut
  import instr_sequencer_pkg::*;
#(
  parameter int LEN_STD   = 3,
  parameter int LEN_LOAD  = 4,
  parameter int LEN_STORE = 3
) (
  input  instr_cls_e       cls_i,
  output logic [CNT_W-1:0] len_o
);

  // Pure lookup, no state.
  always_comb begin
    len_o = '0;
    case (cls_i)
      CLS_STD:   len_o = CNT_W'(LEN_STD);
      CLS_LOAD:  len_o = CNT_W'(LEN_LOAD);
      CLS_STORE: len_o = CNT_W'(LEN_STORE);
      default:   len_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: owns the PC, reads the synchronous instruction
// memory, and holds each instruction on the CU bus for its class length,
// prefetching the next word so back-to-back issue has no bubble.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5,
  parameter int RESET_PC    = 0,
  parameter int LEN_STD     = 3,
  parameter int LEN_LOAD    = 4,
  parameter int LEN_STORE   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop_req,
  input  logic                 step_mode,
  input  logic                 pc_load,
  input  logic [ADDR_BITS-1:0] pc_in,
  instr_sequencer_if.master    bus,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 halted,
  output logic [15:0]          retired_cnt
);

  seq_state_e             state_q;
  logic [ADDR_BITS-1:0]   pc_q;
  logic [ADDR_BITS-1:0]   imem_addr_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   retire_q;
  logic                   halted_q;
  logic                   first_issue_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [15:0]            ret_cnt_q;

  instr_cls_e             rdata_cls;
  logic [CNT_W-1:0]       len_d;
  logic [CNT_W-1:0]       cnt_load_d;
  logic [ADDR_BITS-1:0]   pc_inc_d;
  logic                   last_cycle_d;
  logic                   leave_d;
  logic                   load_next_d;

  assign rdata_cls = instr_cls_e'(bus.imem_rdata[INSTR_WIDTH-1 -: 2]);

  issue_len_lut #(
    .LEN_STD   (LEN_STD),
    .LEN_LOAD  (LEN_LOAD),
    .LEN_STORE (LEN_STORE)
  ) u_len_lut (
    .cls_i (rdata_cls),
    .len_o (len_d)
  );

  // Next-instruction decisions shared by the LOAD and end-of-ISSUE paths.
  always_comb begin
    pc_inc_d     = pc_q + 1'b1;
    // The first instruction after IDLE gets one extra cycle so the CU can
    // spend its reset-state sampling cycle without losing an issue cycle.
    cnt_load_d   = len_d + CNT_W'(first_issue_q);
    last_cycle_d = (state_q == S_ISSUE) && (cnt_q == CNT_W'(1));
    leave_d      = last_cycle_d && (stop_req || step_mode);
    load_next_d  = ((state_q == S_LOAD) || (last_cycle_d && !leave_d)) &&
                   (rdata_cls != CLS_HALT);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= ADDR_BITS'(RESET_PC);
      imem_addr_q   <= ADDR_BITS'(RESET_PC);
      instr_q       <= '0;
      valid_q       <= 1'b0;
      retire_q      <= 1'b0;
      halted_q      <= 1'b0;
      first_issue_q <= 1'b1;
      cnt_q         <= '0;
      ret_cnt_q     <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          instr_q <= '0;
          valid_q <= 1'b0;
          if (pc_load) begin
            pc_q <= pc_in;
          end else if (start) begin
            state_q     <= S_FETCH;
            imem_addr_q <= pc_q;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (rdata_cls == CLS_HALT) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          cnt_q <= cnt_q - 1'b1;
          // Address the next word one cycle ahead of the decision cycle.
          if (cnt_q == CNT_W'(3)) imem_addr_q <= pc_q;
          if (cnt_q == CNT_W'(2)) retire_q <= 1'b1;
          if (last_cycle_d) begin
            ret_cnt_q <= ret_cnt_q + 16'd1;
            if (leave_d) begin
              state_q       <= S_IDLE;
              instr_q       <= '0;
              valid_q       <= 1'b0;
              first_issue_q <= 1'b1;
            end else if (rdata_cls == CLS_HALT) begin
              state_q  <= S_HALTED;
              instr_q  <= '0;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          instr_q <= '0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (load_next_d) begin
        state_q       <= S_ISSUE;
        instr_q       <= bus.imem_rdata;
        valid_q       <= 1'b1;
        pc_q          <= pc_inc_d;
        cnt_q         <= cnt_load_d;
        first_issue_q <= 1'b0;
        // A two-cycle instruction must prefetch straight away.
        if (cnt_load_d == CNT_W'(2)) imem_addr_q <= pc_inc_d;
      end
    end
  end

  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.retire      = retire_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign retired_cnt     = ret_cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer. The reference model expands a run
// into the list of instructions it should issue (from memory contents, PC,
// class lengths and the stop/step/halt rules), then into a per-cycle
// expectation of the CU bus.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop_req;
  logic        step_mode;
  logic        pc_load;
  logic [4:0]  pc_in;
  logic [4:0]  pc;
  logic        halted;
  logic [15:0] retired_cnt;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop_req    (stop_req),
    .step_mode   (step_mode),
    .pc_load     (pc_load),
    .pc_in       (pc_in),
    .bus         (bus),
    .pc          (pc),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  logic [19:0] mem [32];

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [19:0] instr;
    bit          retire;
    bit          fin;
    bit          addr_chk;
    logic [4:0]  addr;
  } ent_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [4:0]  m_pc;
  logic [15:0] m_ret;
  bit          m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int len_of(input logic [1:0] cls);
    case (cls)
      2'b01:   return 3;
      2'b10:   return 4;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [19:0] rand_word(input logic [1:0] cls);
    logic [17:0] payload;
    payload = 18'($urandom);
    return {cls, payload};
  endfunction

  task automatic check_reset();
    chk("rst_instr",  32'(bus.instr_out),   32'h0);
    chk("rst_valid",  32'(bus.instr_valid), 32'h0);
    chk("rst_retire", 32'(bus.retire),      32'h0);
    chk("rst_halted", 32'(halted),          32'h0);
    chk("rst_retcnt", 32'(retired_cnt),     32'h0);
    chk("rst_pc",     32'(pc),              32'h0);
    chk("rst_addr",   32'(bus.imem_addr),   32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc   = 5'd0;
    m_ret  = 16'd0;
    m_halt = 1'b0;
    check_reset();
  endtask

  // One start from IDLE: run up to k instructions (or one in step mode),
  // stopping early if a halt word is reached.
  task automatic run_seq(input int k, input bit step);
    ent_t        tr[$];
    ent_t        e;
    int          n;
    int          len;
    bit          first;
    bit          hit_halt;
    bit          fin;
    logic [4:0]  p;
    logic [19:0] w;

    p = m_pc; n = 0; first = 1'b1; hit_halt = 1'b0;
    while (1) begin
      w = mem[p];
      if (w[19:18] == 2'b00) begin
        hit_halt = 1'b1;
        break;
      end
      len = len_of(w[19:18]) + (first ? 1 : 0);
      first = 1'b0;
      n++;
      fin = (n >= k) || step;
      for (int c = 0; c < len; c++) begin
        e.instr    = w;
        e.retire   = (c == len - 1);
        e.fin      = fin;
        e.addr_chk = (c == len - 2);
        e.addr     = p + 5'd1;
        tr.push_back(e);
      end
      p = p + 5'd1;
      if (fin) break;
    end

    step_mode = step;
    start     = 1'b1;
    pc_load   = 1'b0;
    tick();
    chk("fetch_valid", 32'(bus.instr_valid), 32'h0);
    chk("fetch_addr",  32'(bus.imem_addr),   32'(m_pc));
    start    = 1'($urandom);
    pc_load  = 1'($urandom);
    pc_in    = 5'($urandom);
    stop_req = 1'($urandom);
    tick();
    chk("load_valid", 32'(bus.instr_valid), 32'h0);
    chk("load_instr", 32'(bus.instr_out),   32'h0);
    stop_req = 1'($urandom);
    foreach (tr[i]) begin
      tick();
      chk("issue_instr",  32'(bus.instr_out),   32'(tr[i].instr));
      chk("issue_valid",  32'(bus.instr_valid), 32'h1);
      chk("issue_retire", 32'(bus.retire),      32'(tr[i].retire));
      chk("issue_halted", 32'(halted),          32'h0);
      if (tr[i].addr_chk) chk("prefetch_addr", 32'(bus.imem_addr), 32'(tr[i].addr));
      start   = 1'($urandom);
      pc_load = 1'($urandom);
      pc_in   = 5'($urandom);
      if (tr[i].retire) stop_req = tr[i].fin ? (step ? 1'($urandom) : 1'b1) : 1'b0;
      else              stop_req = 1'($urandom);
    end
    tick();
    start = 1'b0; pc_load = 1'b0; stop_req = 1'b0;
    m_pc  = p;
    m_ret = m_ret + 16'(n);
    if (hit_halt) m_halt = 1'b1;
    chk("end_valid",  32'(bus.instr_valid), 32'h0);
    chk("end_instr",  32'(bus.instr_out),   32'h0);
    chk("end_retire", 32'(bus.retire),      32'h0);
    chk("end_halted", 32'(halted),          32'(m_halt));
    chk("end_pc",     32'(pc),              32'(m_pc));
    chk("end_retcnt", 32'(retired_cnt),     32'(m_ret));
  endtask

  task automatic check_halt_sticky();
    start   = 1'b1;
    pc_load = 1'b1;
    pc_in   = 5'($urandom);
    tick();
    tick();
    start = 1'b0; pc_load = 1'b0;
    chk("halt_sticky", 32'(halted),          32'h1);
    chk("halt_pc",     32'(pc),              32'(m_pc));
    chk("halt_valid",  32'(bus.instr_valid), 32'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop_req = 1'b0; step_mode = 1'b0;
    pc_load = 1'b0; pc_in = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 20'h0;
    tick();
    do_reset();

    // Straight-line program ending in halt.
    mem[0] = 20'h41230; mem[1] = 20'h80050; mem[2] = 20'hC0060; mem[3] = 20'h00000;
    run_seq(100, 1'b0);
    chk("prog_pc",     32'(pc),          32'd3);
    chk("prog_retcnt", 32'(retired_cnt), 32'd3);
    check_halt_sticky();
    do_reset();

    // Single-step through std_ops.
    for (int i = 0; i < 4; i++) mem[i] = rand_word(2'b01);
    for (int i = 0; i < 3; i++) run_seq(1, 1'b1);
    chk("step_pc", 32'(pc), 32'd3);

    // Stop during a loadR, then resume.
    mem[3] = 20'h80AAA; mem[4] = rand_word(2'b01); mem[5] = rand_word(2'b11);
    mem[6] = 20'h00000;
    run_seq(1, 1'b0);
    run_seq(5, 1'b0);
    do_reset();

    // pc_load wins over start; then wrap from 31 to 0.
    pc_load = 1'b1; pc_in = 5'd31; start = 1'b1;
    tick();
    pc_load = 1'b0; start = 1'b0;
    chk("pcload_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("pcload_idle", 32'(bus.instr_valid), 32'h0);
    chk("pcload_pc",   32'(pc),              32'd31);
    chk("pcload_addr", 32'(bus.imem_addr),   32'd0);
    m_pc = 5'd31;
    mem[31] = rand_word(2'b01); mem[0] = rand_word(2'b11); mem[1] = 20'h00000;
    run_seq(2, 1'b0);

    // Reset in the middle of an instruction.
    pc_load = 1'b1; pc_in = 5'd5;
    tick();
    pc_load = 1'b0;
    mem[5] = rand_word(2'b01);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) tick();
    chk("abort_addr",  32'(bus.imem_addr),   32'd6);
    chk("abort_valid", 32'(bus.instr_valid), 32'h1);
    do_reset();

    // Random programs, PCs, run lengths and step mode.
    for (int it = 0; it < 30; it++) begin
      if (m_halt || ($urandom_range(0, 5) == 0)) do_reset();
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 32; i++)
          mem[i] = rand_word(($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
      end
      if ($urandom_range(0, 2) == 0) begin
        pc_load = 1'b1;
        pc_in   = 5'($urandom);
        start   = 1'($urandom);
        tick();
        pc_load = 1'b0; start = 1'b0;
        m_pc = pc_in;
        tick();
        chk("rnd_pcload", 32'(pc), 32'(m_pc));
      end
      run_seq($urandom_range(1, 5), ($urandom_range(0, 3) == 0));
      if (m_halt) check_halt_sticky();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
